// File: rtl/rs_age_issue.sv
// rs_age_issue: age-ordered reservation station with per-class oldest-first issue; optional same-cycle wakeup bypass via RS_WAKEUP_BYPASS_EN
module rs_age_issue #(
   parameter int DEPTH = 16,
   parameter int N = 2,
   parameter int CDB_W = 2,
   parameter int NUM_CLS = 5,
   parameter int FU_PER_CLS = 2,
   parameter int PREG_W = 6,
   parameter int BR_W = 4,
   parameter int PAYLOAD_W = 64,
   localparam int CLS_W = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1,
   localparam int FS_W = $clog2(N + 1),
   localparam int OCC_W = $clog2(DEPTH + 1),
   localparam int NFU = NUM_CLS * FU_PER_CLS
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N-1:0]               dis_valid,
   input  logic [N*CLS_W-1:0]         dis_cls,
   input  logic [N*PREG_W-1:0]        dis_t1,
   input  logic [N*PREG_W-1:0]        dis_t2,
   input  logic [N-1:0]               dis_t1_rdy,
   input  logic [N-1:0]               dis_t2_rdy,
   input  logic [N*BR_W-1:0]          dis_bmask,
   input  logic [N*PAYLOAD_W-1:0]     dis_payload,
   output logic [FS_W-1:0]            free_slots,
   input  logic [CDB_W-1:0]           cdb_valid,
   input  logic [CDB_W*PREG_W-1:0]    cdb_tag,
   input  logic                       br_valid,
   input  logic                       br_squash,
   input  logic [BR_W-1:0]            br_id,
   input  logic [NFU-1:0]             fu_free,
   output logic [NFU-1:0]             iss_valid,
   output logic [NFU*PREG_W-1:0]      iss_t1,
   output logic [NFU*PREG_W-1:0]      iss_t2,
   output logic [NFU*BR_W-1:0]        iss_bmask,
   output logic [NFU*PAYLOAD_W-1:0]   iss_payload,
   output logic [OCC_W-1:0]           occupancy
);
   localparam int LW = (N > 1) ? $clog2(N) : 1;

   logic [DEPTH-1:0]     valid, t1_rdy, t2_rdy, wake1, wake2, rdy1, rdy2, sq_hit, req, issued, wr;
   logic [PREG_W-1:0]    t1 [DEPTH];
   logic [PREG_W-1:0]    t2 [DEPTH];
   logic [CLS_W-1:0]     cls [DEPTH];
   logic [BR_W-1:0]      bmask [DEPTH];
   logic [PAYLOAD_W-1:0] payload [DEPTH];
   logic [DEPTH-1:0]     age [DEPTH];
   logic [OCC_W-1:0]     rank [DEPTH];
   logic [OCC_W-1:0]     frank [DEPTH];
   logic [LW-1:0]        src [DEPTH];
   logic [DEPTH-1:0]     sel [NFU];
   logic [OCC_W-1:0]     fk [NFU];
   logic [CLS_W-1:0]     l_cls [N];
   logic [PREG_W-1:0]    l_t1 [N];
   logic [PREG_W-1:0]    l_t2 [N];
   logic [BR_W-1:0]      l_bm [N];
   logic [PAYLOAD_W-1:0] l_pay [N];
   logic [OCC_W-1:0]     l_k [N];
   logic [N-1:0]         l_r1, l_r2, wr_lane;
   logic [BR_W-1:0]      clr_mask;
   logic [OCC_W-1:0]     avail;
   logic                 squash;
   int                   occ_next;

   // tag 0 is hardwired ready; otherwise ready on any valid CDB match
   function automatic logic cdb_hit(input logic [PREG_W-1:0] tag, input logic [CDB_W-1:0] cv,
                                    input logic [CDB_W*PREG_W-1:0] ct);
      cdb_hit = (tag == '0);
      for (int k = 0; k < CDB_W; k++)
         if (cv[k] && ct[k*PREG_W +: PREG_W] == tag) cdb_hit = 1'b1;
   endfunction

   assign squash = br_valid && br_squash;
   assign clr_mask = (br_valid && !br_squash) ? br_id : '0;
   assign avail = OCC_W'(DEPTH) - occupancy;
   assign free_slots = (avail < OCC_W'(N)) ? FS_W'(avail) : FS_W'(N);

`ifdef RS_WAKEUP_BYPASS_EN
   assign rdy1 = t1_rdy | wake1;
   assign rdy2 = t2_rdy | wake2;
`else
   assign rdy1 = t1_rdy;
   assign rdy2 = t2_rdy;
`endif
   assign req = valid & ~sq_hit & rdy1 & rdy2;

   // per-entry CDB wakeup and squash hit against the current branch event
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         wake1[e] = cdb_hit(t1[e], cdb_valid, cdb_tag);
         wake2[e] = cdb_hit(t2[e], cdb_valid, cdb_tag);
         sq_hit[e] = valid[e] && squash && |(bmask[e] & br_id);
      end
   end

   // age rank among same-class requesters: number of older requesters
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         rank[e] = '0;
         for (int j = 0; j < DEPTH; j++)
            rank[e] = rank[e] + OCC_W'(req[j] && cls[j] == cls[e] && age[j][e]);
      end
   end

   // the k-th free FU of a class takes the requester of rank k
   always_comb begin
      for (int c = 0; c < NUM_CLS; c++) begin
         for (int f = 0; f < FU_PER_CLS; f++) begin
            fk[c*FU_PER_CLS+f] = '0;
            for (int g = 0; g < f; g++)
               fk[c*FU_PER_CLS+f] = fk[c*FU_PER_CLS+f] + OCC_W'(fu_free[c*FU_PER_CLS+g]);
            for (int e = 0; e < DEPTH; e++)
               sel[c*FU_PER_CLS+f][e] = fu_free[c*FU_PER_CLS+f] && req[e] &&
                                        cls[e] == CLS_W'(c) && rank[e] == fk[c*FU_PER_CLS+f];
         end
      end
   end

   // issue muxes; unused slots drive zeros, in-flight branch clear applied to the mask
   always_comb begin
      iss_valid = '0;
      iss_t1 = '0;
      iss_t2 = '0;
      iss_bmask = '0;
      iss_payload = '0;
      issued = '0;
      for (int s = 0; s < NFU; s++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (sel[s][e]) begin
               iss_valid[s] = 1'b1;
               iss_t1[s*PREG_W +: PREG_W] = t1[e];
               iss_t2[s*PREG_W +: PREG_W] = t2[e];
               iss_bmask[s*BR_W +: BR_W] = bmask[e] & ~clr_mask;
               iss_payload[s*PAYLOAD_W +: PAYLOAD_W] = payload[e];
               issued[e] = 1'b1;
            end
         end
      end
   end

   // lane acceptance and mapping of written lanes onto the lowest free entries
   always_comb begin
      for (int i = 0; i < N; i++) begin
         l_cls[i] = dis_cls[i*CLS_W +: CLS_W];
         l_t1[i] = dis_t1[i*PREG_W +: PREG_W];
         l_t2[i] = dis_t2[i*PREG_W +: PREG_W];
         l_bm[i] = dis_bmask[i*BR_W +: BR_W] & ~clr_mask;
         l_pay[i] = dis_payload[i*PAYLOAD_W +: PAYLOAD_W];
         l_r1[i] = dis_t1_rdy[i] | cdb_hit(l_t1[i], cdb_valid, cdb_tag);
         l_r2[i] = dis_t2_rdy[i] | cdb_hit(l_t2[i], cdb_valid, cdb_tag);
         wr_lane[i] = dis_valid[i] && (FS_W'(i) < free_slots) &&
                      !(squash && |(dis_bmask[i*BR_W +: BR_W] & br_id));
      end
      for (int i = 0; i < N; i++) begin
         l_k[i] = '0;
         for (int g = 0; g < i; g++) l_k[i] = l_k[i] + OCC_W'(wr_lane[g]);
      end
      for (int e = 0; e < DEPTH; e++) begin
         frank[e] = '0;
         for (int j = 0; j < e; j++) frank[e] = frank[e] + OCC_W'(!valid[j]);
         wr[e] = 1'b0;
         src[e] = '0;
         for (int i = 0; i < N; i++) begin
            if (!valid[e] && wr_lane[i] && frank[e] == l_k[i]) begin
               wr[e] = 1'b1;
               src[e] = LW'(i);
            end
         end
      end
   end

   // occupancy bookkeeping; issued and squashed sets never overlap
   always_comb occ_next = int'(occupancy) + $countones(wr) - $countones(issued) - $countones(sq_hit);

   // entry state, readiness, masks and age matrix update
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
         occupancy <= '0;
         for (int e = 0; e < DEPTH; e++) age[e] <= '0;
      end else begin
         assert (occ_next >= 0 && occ_next <= DEPTH);
         occupancy <= OCC_W'(occ_next);
         for (int e = 0; e < DEPTH; e++) begin
            valid[e] <= wr[e] | (valid[e] & ~issued[e] & ~sq_hit[e]);
            t1_rdy[e] <= wr[e] ? l_r1[src[e]] : (t1_rdy[e] | wake1[e]);
            t2_rdy[e] <= wr[e] ? l_r2[src[e]] : (t2_rdy[e] | wake2[e]);
            bmask[e] <= wr[e] ? l_bm[src[e]] : (bmask[e] & ~clr_mask);
            if (wr[e]) begin
               t1[e] <= l_t1[src[e]];
               t2[e] <= l_t2[src[e]];
               cls[e] <= l_cls[src[e]];
               payload[e] <= l_pay[src[e]];
            end
            for (int j = 0; j < DEPTH; j++)
               age[e][j] <= wr[e] ? (wr[j] && src[j] > src[e]) : (wr[j] ? 1'b1 : age[e][j]);
         end
      end
   end
endmodule

// File: tb/tb_rs_age_issue.sv
// tb_rs_age_issue: table-driven directed checks of rs_age_issue plus full/reset sequences
module tb_rs_age_issue;
   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    dis_valid;
   logic [5:0]    dis_cls;
   logic [11:0]   dis_t1, dis_t2;
   logic [1:0]    dis_t1_rdy, dis_t2_rdy;
   logic [7:0]    dis_bmask;
   logic [127:0]  dis_payload;
   logic [1:0]    free_slots;
   logic [1:0]    cdb_valid;
   logic [11:0]   cdb_tag;
   logic          br_valid, br_squash;
   logic [3:0]    br_id;
   logic [9:0]    fu_free;
   logic [9:0]    iss_valid;
   logic [59:0]   iss_t1, iss_t2;
   logic [39:0]   iss_bmask;
   logic [639:0]  iss_payload;
   logic [4:0]    occupancy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] dv;
      logic [2:0] ca;
      logic [5:0] t1a;
      logic [7:0] pa;
      logic [3:0] bma;
      logic [2:0] cb;
      logic [5:0] t1b;
      logic [7:0] pb;
      logic [3:0] bmb;
      logic [1:0] r1;
      logic       cv;
      logic [5:0] ct;
      logic       bv, bs;
      logic [3:0] bid;
      logic [9:0] ff;
      logic [9:0] eiv;
      logic [5:0] et0, et1;
      logic [3:0] eb0;
      logic [7:0] ep0;
      logic [4:0] eocc;
      logic [1:0] efs;
   } vec_t;

   vec_t cur;
   vec_t vecs[$];

   rs_age_issue dut (
      .clock(clock), .reset(reset), .dis_valid(dis_valid), .dis_cls(dis_cls),
      .dis_t1(dis_t1), .dis_t2(dis_t2), .dis_t1_rdy(dis_t1_rdy), .dis_t2_rdy(dis_t2_rdy),
      .dis_bmask(dis_bmask), .dis_payload(dis_payload), .free_slots(free_slots),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .br_valid(br_valid), .br_squash(br_squash),
      .br_id(br_id), .fu_free(fu_free), .iss_valid(iss_valid), .iss_t1(iss_t1), .iss_t2(iss_t2),
      .iss_bmask(iss_bmask), .iss_payload(iss_payload), .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic row(input logic [1:0] dv, input logic [2:0] ca, input logic [5:0] t1a,
                      input logic [7:0] pa, input logic [3:0] bma, input logic [2:0] cb,
                      input logic [5:0] t1b, input logic [7:0] pb, input logic [3:0] bmb,
                      input logic [1:0] r1);
      cur.dv = dv; cur.ca = ca; cur.t1a = t1a; cur.pa = pa; cur.bma = bma;
      cur.cb = cb; cur.t1b = t1b; cur.pb = pb; cur.bmb = bmb; cur.r1 = r1;
   endtask

   task automatic io(input logic cv, input logic [5:0] ct, input logic bv, input logic bs,
                     input logic [3:0] bid, input logic [9:0] ff);
      cur.cv = cv; cur.ct = ct; cur.bv = bv; cur.bs = bs; cur.bid = bid; cur.ff = ff;
   endtask

   task automatic ex(input logic [9:0] eiv, input logic [5:0] et0, input logic [5:0] et1,
                     input logic [3:0] eb0, input logic [7:0] ep0, input logic [4:0] eocc,
                     input logic [1:0] efs);
      cur.eiv = eiv; cur.et0 = et0; cur.et1 = et1; cur.eb0 = eb0; cur.ep0 = ep0;
      cur.eocc = eocc; cur.efs = efs;
      vecs.push_back(cur);
      cur = '0;
   endtask

   task automatic drive(input vec_t v);
      dis_valid = v.dv;
      dis_cls = {v.cb, v.ca};
      dis_t1 = {v.t1b, v.t1a};
      dis_t2 = '0;
      dis_t1_rdy = v.r1;
      dis_t2_rdy = 2'b11;
      dis_bmask = {v.bmb, v.bma};
      dis_payload = {56'h0, v.pb, 56'h0, v.pa};
      cdb_valid = {1'b0, v.cv};
      cdb_tag = {6'd0, v.ct};
      br_valid = v.bv;
      br_squash = v.bs;
      br_id = v.bid;
      fu_free = v.ff;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      cur = '0;
      // two ready ALU ops issue next cycle in lane order
      io(0, 0, 0, 0, 0, 0);                                  ex(0, 0, 0, 0, 0, 0, 2);
      row(2'b11, 0, 1, 1, 0, 0, 2, 2, 0, 2'b11);             ex(0, 0, 0, 0, 0, 0, 2);
      io(0, 0, 0, 0, 0, 10'h003);                            ex(10'h003, 1, 2, 0, 1, 2, 2);
      io(0, 0, 0, 0, 0, 10'h003);                            ex(0, 0, 0, 0, 0, 0, 2);
      // only FU1 free: oldest goes to it
      row(2'b11, 0, 3, 3, 0, 0, 4, 4, 0, 2'b11);             ex(0, 0, 0, 0, 0, 0, 2);
      io(0, 0, 0, 0, 0, 10'h002);                            ex(10'h002, 0, 3, 0, 0, 2, 2);
      io(0, 0, 0, 0, 0, 10'h002);                            ex(10'h002, 0, 4, 0, 0, 1, 2);
      ex(0, 0, 0, 0, 0, 0, 2);
      // A, B, C waiting on tag 5 with one ALU free
      row(2'b01, 0, 5, 8'hA, 0, 0, 0, 0, 0, 2'b00); io(0, 0, 0, 0, 0, 1); ex(0, 0, 0, 0, 0, 0, 2);
      row(2'b01, 0, 5, 8'hB, 0, 0, 0, 0, 0, 2'b00); io(0, 0, 0, 0, 0, 1); ex(0, 0, 0, 0, 0, 1, 2);
      row(2'b01, 0, 5, 8'hC, 0, 0, 0, 0, 0, 2'b00); io(0, 0, 0, 0, 0, 1); ex(0, 0, 0, 0, 0, 2, 2);
`ifdef RS_WAKEUP_BYPASS_EN
      io(1, 5, 0, 0, 0, 1); ex(1, 5, 0, 0, 8'hA, 3, 2);
      io(0, 0, 0, 0, 0, 1); ex(1, 5, 0, 0, 8'hB, 2, 2);
      io(0, 0, 0, 0, 0, 1); ex(1, 5, 0, 0, 8'hC, 1, 2);
      io(0, 0, 0, 0, 0, 1); ex(0, 0, 0, 0, 0, 0, 2);
`else
      io(1, 5, 0, 0, 0, 1); ex(0, 0, 0, 0, 0, 3, 2);
      io(0, 0, 0, 0, 0, 1); ex(1, 5, 0, 0, 8'hA, 3, 2);
      io(0, 0, 0, 0, 0, 1); ex(1, 5, 0, 0, 8'hB, 2, 2);
      io(0, 0, 0, 0, 0, 1); ex(1, 5, 0, 0, 8'hC, 1, 2);
`endif
      ex(0, 0, 0, 0, 0, 0, 2);
      // dispatch with same-cycle CDB match captures ready
      row(2'b01, 0, 7, 8'h77, 0, 0, 0, 0, 0, 2'b00); io(1, 7, 0, 0, 0, 1); ex(0, 0, 0, 0, 0, 0, 2);
      io(0, 0, 0, 0, 0, 1);                                  ex(1, 7, 0, 0, 8'h77, 1, 2);
      ex(0, 0, 0, 0, 0, 0, 2);
      // squash br 0010 while issuing; same-cycle dispatch with 0010 dropped
      row(2'b11, 0, 8, 8'h88, 4'b0010, 0, 9, 8'h99, 4'b0001, 2'b11); ex(0, 0, 0, 0, 0, 0, 2);
      row(2'b01, 0, 10, 8'h10, 4'b0010, 0, 0, 0, 0, 2'b01);
      io(0, 0, 1, 1, 4'b0010, 10'h003);                      ex(1, 9, 0, 4'b0001, 8'h99, 2, 2);
      io(0, 0, 0, 0, 0, 10'h003);                            ex(0, 0, 0, 0, 0, 0, 2);
      // clear br 0100: issue, stored and incoming masks lose bit 2
      row(2'b11, 0, 11, 8'h11, 4'b0110, 0, 12, 8'h12, 4'b0100, 2'b11); ex(0, 0, 0, 0, 0, 0, 2);
      row(2'b01, 0, 13, 8'h13, 4'b0101, 0, 0, 0, 0, 2'b01);
      io(0, 0, 1, 0, 4'b0100, 1);                            ex(1, 11, 0, 4'b0010, 8'h11, 2, 2);
      io(0, 0, 0, 0, 0, 1);                                  ex(1, 12, 0, 4'b0000, 8'h12, 2, 2);
      io(0, 0, 0, 0, 0, 1);                                  ex(1, 13, 0, 4'b0001, 8'h13, 1, 2);
      ex(0, 0, 0, 0, 0, 0, 2);
      // MULT and BR classes issue on their own slots
      row(2'b11, 1, 14, 8'h14, 0, 4, 15, 8'h15, 0, 2'b11); io(0, 0, 0, 0, 0, 10'h3FF); ex(0, 0, 0, 0, 0, 0, 2);
      io(0, 0, 0, 0, 0, 10'h3FF);                            ex(10'h104, 0, 0, 0, 0, 2, 2);
      ex(0, 0, 0, 0, 0, 0, 2);

      reset = 1'b1;
      drive('0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(negedge clock);
         chk($sformatf("v%0d_iss_valid", i), 64'(iss_valid), 64'(vecs[i].eiv));
         chk($sformatf("v%0d_iss_t1_s0", i), 64'(iss_t1[5:0]), 64'(vecs[i].et0));
         chk($sformatf("v%0d_iss_t1_s1", i), 64'(iss_t1[11:6]), 64'(vecs[i].et1));
         chk($sformatf("v%0d_iss_bmask_s0", i), 64'(iss_bmask[3:0]), 64'(vecs[i].eb0));
         chk($sformatf("v%0d_iss_payload_s0", i), iss_payload[63:0], 64'(vecs[i].ep0));
         chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
         chk($sformatf("v%0d_free_slots", i), 64'(free_slots), 64'(vecs[i].efs));
         step();
      end

      // fill to 15, then one lane accepted, then full with lanes ignored
      for (int k = 0; k < 7; k++) begin
         row(2'b11, 0, 20, 8'(2 * k), 0, 0, 20, 8'(2 * k + 1), 0, 2'b00);
         drive(cur);
         cur = '0;
         @(negedge clock);
         chk($sformatf("fill%0d_occupancy", k), 64'(occupancy), 64'(2 * k));
         chk($sformatf("fill%0d_free_slots", k), 64'(free_slots), 64'd2);
         step();
      end
      row(2'b01, 0, 20, 8'd14, 0, 0, 0, 0, 0, 2'b00); drive(cur); cur = '0;
      @(negedge clock);
      chk("fill7_occupancy", 64'(occupancy), 64'd14);
      step();
      row(2'b11, 0, 20, 8'd15, 0, 0, 20, 8'd99, 0, 2'b00); drive(cur); cur = '0;
      @(negedge clock);
      chk("one_left_occupancy", 64'(occupancy), 64'd15);
      chk("one_left_free_slots", 64'(free_slots), 64'd1);
      step();
      row(2'b11, 0, 20, 8'd98, 0, 0, 20, 8'd97, 0, 2'b00); drive(cur); cur = '0;
      @(negedge clock);
      chk("full_occupancy", 64'(occupancy), 64'd16);
      chk("full_free_slots", 64'(free_slots), 64'd0);
      step();
      row(2'b11, 0, 20, 8'd96, 0, 0, 20, 8'd95, 0, 2'b00); io(1, 20, 0, 0, 0, 0); drive(cur); cur = '0;
      @(negedge clock);
      chk("full_ignore_occupancy", 64'(occupancy), 64'd16);
      chk("full_ignore_free_slots", 64'(free_slots), 64'd0);
      chk("full_noissue_valid", 64'(iss_valid), 64'd0);
      step();
      io(0, 0, 0, 0, 0, 10'h003); drive(cur); cur = '0;
      @(negedge clock);
      chk("drain_valid", 64'(iss_valid), 64'h3);
      chk("drain_payload_s0", iss_payload[63:0], 64'd0);
      chk("drain_payload_s1", iss_payload[127:64], 64'd1);
      chk("drain_occupancy", 64'(occupancy), 64'd16);
      step();
      // reset mid-operation
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive('0);
      @(negedge clock);
      chk("midreset_valid", 64'(iss_valid), 64'd0);
      chk("midreset_payload_s0", iss_payload[63:0], 64'd0);
      chk("midreset_occupancy", 64'(occupancy), 64'd0);
      chk("midreset_free_slots", 64'(free_slots), 64'd2);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rs_age_issue.md
Name: rs_age_issue

Overview:
- Parametrised successor reservation station: holds dispatched ops until source tags are ready, then issues them to pipelined functional units.
- Generalised in depth, dispatch width, CDB width, FU class count and per-class FU count.
- Issue is oldest-first per class, using an age matrix.
- Handles branch-mask squash/clear, including the dispatch and issue paths in the same cycle.

Parameters:
- DEPTH, 16, number of entries.
- N, 2, dispatch lanes per cycle.
- CDB_W, 2, CDB broadcasts per cycle.
- NUM_CLS, 5, FU classes (ALU, MULT, LD, STORE, BR = 0..4).
- FU_PER_CLS, 2, FUs per class; each class issues at most this many ops per cycle.
- PREG_W, 6, physical register tag width.
- BR_W, 4, branch mask width.
- PAYLOAD_W, 64, opaque decoded payload width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dis_valid  in  N  dispatch lane valid
- dis_cls  in  N x clog2(NUM_CLS)  FU class
- dis_t1, dis_t2  in  N x PREG_W  source tags
- dis_t1_rdy, dis_t2_rdy  in  N  source ready from map table
- dis_bmask  in  N x BR_W  branch mask
- dis_payload  in  N x PAYLOAD_W  decoded fields
- free_slots  out  clog2(N+1)  min(N, DEPTH-occupancy); lanes >= free_slots ignored
- cdb_valid  in  CDB_W  broadcast valid
- cdb_tag  in  CDB_W x PREG_W  completing tag
- br_valid  in  1  branch resolve event
- br_squash  in  1  1 = squash, 0 = clear
- br_id  in  BR_W  one-hot branch bit
- fu_free  in  NUM_CLS x FU_PER_CLS  FU can accept an op this cycle
- iss_valid  out  NUM_CLS x FU_PER_CLS  issue valid
- iss_t1, iss_t2  out  NUM_CLS x FU_PER_CLS x PREG_W  source tags
- iss_bmask  out  NUM_CLS x FU_PER_CLS x BR_W  branch mask
- iss_payload  out  NUM_CLS x FU_PER_CLS x PAYLOAD_W  payload
- occupancy  out  clog2(DEPTH+1)  valid entry count

Behaviour:
Reset:
- All entries invalid; age matrix cleared; occupancy = 0.
- free_slots = min(N, DEPTH); all iss_* outputs = 0.

Issue (combinational from registered state, 0-cycle):
- An entry requests when valid and t1_rdy and t2_rdy.
- Per class, the k-th free FU (ascending index within fu_free[c]) gets the k-th oldest requester.
- Unused FU slots drive iss_valid = 0 and all iss_* fields = 0.
- An issued entry is invalidated at the next edge.

Age matrix:
- age[i][j] = 1 means i is older than j.
- A dispatched entry is younger than all resident entries.
- Among lanes dispatched in the same cycle, lower lane = older.

Dispatch:
- Lane i is accepted iff dis_valid[i] and i < free_slots.
- Accepted lanes are written to the lowest-index invalid entries (computed from registered state) in lane order.
- Slots freed this cycle are not reusable until the next cycle.
- Captured ready bit = dis_tX_rdy OR a match with any valid cdb_tag in the same cycle.

Wakeup:
- A CDB match on t1/t2 of a valid entry sets the ready bit at the edge.
- Tag 0 is always treated as ready.

Branch, squash (br_valid and br_squash):
- Entries with (bmask & br_id) != 0 are invalidated at the edge.
- Their iss_valid is forced to 0 this cycle, and they do not consume an FU slot (next-oldest fills it).
- Accepted dispatch lanes whose bmask hits br_id are dropped: not written, not counted.

Branch, clear (br_valid and !br_squash):
- br_id bit cleared in stored masks, incoming dispatch masks, and the iss_bmask outputs this cycle.

Occupancy:
- Next occupancy = occupancy + written - issued - squashed.
- Issued and squashed sets are disjoint.
- Occupancy is never above DEPTH and never below 0; an assertion fires otherwise.

Boundaries:
- Full: free_slots = 0, all lanes ignored.
- Simultaneous issue, dispatch and squash in one cycle follow the rules above.
- Reset mid-operation drops all entries and outputs zeros in the following cycle.

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- When defined: a CDB match in the current cycle counts as ready for the issue request, so a resident entry can issue in the same cycle as its last wakeup. The issued tag is the stored one.
- When undefined: an entry issues no earlier than the cycle after its wakeup edge.
- Dispatch-cycle ready capture is identical in both modes.

Test Plan:
- Reset, then dispatch 2 ALU ops (both ready) with fu_free[0] = 2'b11 -> next cycle both ALU slots issue, ordered lane0 then lane1; occupancy returns 2 -> 0.
- Dispatch ALU ops A, B, C in successive cycles, all waiting on tag 5, with one ALU free; CDB tag 5 -> without bypass, A issues one cycle after the CDB, then B, then C.
- Run the same scenario with RS_WAKEUP_BYPASS_EN -> A issues in the CDB cycle itself.
- Fill all 16 entries with unready ops -> free_slots = 0; dispatch attempts are ignored; occupancy stays 16.
- Entries with bmask 4'b0010 and 4'b0001, both ready, issuing in the squash cycle with br_id = 4'b0010 -> the 0010 entry is not issued and is removed; the 0001 entry issues; a same-cycle dispatch with bmask 0010 is dropped.
- Clear br_id = 4'b0100 while issuing an entry with bmask 4'b0110 -> iss_bmask = 4'b0010; stored and incoming masks lose bit 2.
- Dispatch an op whose t1 = 7 in the same cycle as CDB tag 7 -> the op is captured ready and issues the next cycle.
